uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. Captures every data word the receiver presents with its one-cycle `ready` pulse and holds it in a circular FIFO. Presents the oldest word to the consumer over a valid/ack handshake, so that bytes arriving back-to-back at line rate are not lost while the consumer is busy. Reports occupancy, full/empty status and a sticky overflow flag.

## Interface
- `DATA_WIDTH`, 8, word width; must match the receiver's `DATA_WIDTH`.
- `DEPTH`, 16, number of entries; power of two, 2..256.
- `clk`  in  1  single clock for all logic, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  DATA_WIDTH  word from the receiver; sampled only when `in_ready`=1.
- `in_ready`  in  1  receiver "word complete" strobe, one `clk` cycle wide; each high cycle is one write.
- `out_data`  out  DATA_WIDTH  head-of-queue word; forced to 0 when `out_valid`=0.
- `out_valid`  out  1  FIFO non-empty; `out_data` is meaningful.
- `out_ack`  in  1  consumer pops the head at the rising edge where `out_valid`=1 and `out_ack`=1.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  out  1  `count`==DEPTH.
- `empty`  out  1  `count`==0.
- `overflow`  out  1  sticky; set when a write arrives while full and no pop occurs in the same cycle.
- `overflow_clr`  in  1  clears `overflow`.

## Operation
- Storage: DEPTH×DATA_WIDTH array, write pointer `wr_ptr`, read pointer `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH. Occupancy is held in a separate `count` register; full/empty are not derived from pointer equality.
- Push condition: `in_ready`=1. Pop condition: `out_ack`=1 and `out_valid`=1. `out_ack` with `out_valid`=0 is ignored.
- Push only, not full: write `mem[wr_ptr]`, `wr_ptr`+1, `count`+1.
- Pop only: `rd_ptr`+1, `count`-1.
- Push and pop together (any non-empty state, including full): both pointers advance and `count` is unchanged. No overflow.
- Push and pop together when empty: the pop is ignored and the push proceeds as push-only.
- Push while full, no pop: handling depends on the Configuration section. `overflow` is set in both modes.
- `overflow`: the set condition has priority over `overflow_clr` in the same cycle.
- Outputs: `out_valid`, `empty`, `full` and `count` all come from registered state.
- `out_data` is a combinational read of `mem[rd_ptr]`, gated by `out_valid` (first-word-fall-through).
- Reset values: pointers 0, `count` 0, `out_valid` 0, `out_data` 0, `empty` 1, `full` 0, `overflow` 0. Array contents are not reset.
- Reset asserted mid-operation discards all queued words immediately, with no pop of in-flight data.

## Timing
- Write latency: push at edge N gives `out_valid`=1 with the word on `out_data` after edge N (from an empty FIFO), visible in cycle N+1.
- Pop at edge N: the next word is on `out_data` in cycle N+1. If the popped word was the last one, `out_valid`=0 in cycle N+1.
- Sustained throughput is one push and one pop per cycle. The receiver strobes far slower, so a full FIFO is reached only when the consumer stalls.
- `full`, `empty` and `count` update on the same edge as the pointers.

## Configuration
- Macro `UART_RX_FIFO_OVERWRITE_EN`.
  - Defined: a push while full with no pop overwrites the oldest entry. `mem[wr_ptr]` is written, both `wr_ptr` and `rd_ptr` advance, and `count` stays DEPTH, so the newest DEPTH words are kept.
  - Undefined (default): a push while full with no pop is dropped. Pointers, `count` and the array are unchanged, so the oldest DEPTH words are kept.

## Structure
- Shared package `uart_pkg`: `UART_DATA_WIDTH` default (8), `UART_RX_FIFO_DEPTH` default (16), and the pointer/count width helper expressions used by both receive and transmit buffering.
- One sub-module: `uart_fifo_mem`, a simple dual-port array with a registered write port (`we`, `waddr`, `wdata`) and a combinational read port (`raddr`, `rdata`). All pointer, count and flag logic stays in `uart_rx_fifo`.

## Test plan
- Reset, then a single push of 0xA5 -> next cycle `out_valid`=1, `out_data`=0xA5, `count`=1. Ack one cycle -> `out_valid`=0, `out_data`=0, `empty`=1.
- Push 0x00..0x0F with DEPTH=16 and no ack -> `full`=1, `count`=16, `overflow`=0. Drain with continuous ack -> words 0x00..0x0F in order, then `empty`=1.
- While full, push 0x55 with no ack -> `overflow`=1. Default build: first pop returns 0x00 and 0x55 is absent. Overwrite build: first pop returns 0x01 and the last pop returns 0x55.
- While full, push 0x77 and ack in the same cycle -> `count` stays 16, `overflow` stays 0, and 0x77 is the last word drained.
- Assert `overflow_clr` on the same cycle as a dropping push -> `overflow` stays 1. Assert `overflow_clr` on the next cycle with no push -> `overflow`=0.
- Queue 5 words, pulse `reset` asynchronously between edges -> outputs go to reset values immediately. A later push of 0x3C is the first word out.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART defaults and pointer/count width helpers for the receive and transmit buffers.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH    = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH = 16;

  // Index width into a DEPTH-entry array; wraps naturally for power-of-two depths.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy needs one extra bit to represent the full value DEPTH.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: registered write port, combinational read port, contents not reset.
module uart_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: first-word-fall-through read, sticky overflow.
// Define UART_RX_FIFO_OVERWRITE_EN to overwrite the oldest entry on a push while full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter  int unsigned DEPTH      = UART_RX_FIFO_DEPTH,
  localparam int unsigned AW         = ptr_width(DEPTH),
  localparam int unsigned CW         = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ack,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr_nxt;
  logic [AW-1:0]         rd_ptr_nxt;
  logic [CW-1:0]         count_nxt;
  logic                  push;
  logic                  pop;
  logic                  we;
  logic                  ovf_set;
  logic [DATA_WIDTH-1:0] rdata;

  // Next pointer/occupancy; a pop with nothing queued is ignored via out_valid.
  always_comb begin
    push       = in_ready;
    pop        = out_ack & out_valid;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    we         = 1'b0;
    ovf_set    = 1'b0;
    if (push && pop) begin
      we         = 1'b1;
      wr_ptr_nxt = wr_ptr + AW'(1);
      rd_ptr_nxt = rd_ptr + AW'(1);
    end else if (push && !full) begin
      we         = 1'b1;
      wr_ptr_nxt = wr_ptr + AW'(1);
      count_nxt  = count + CW'(1);
    end else if (push) begin
      ovf_set = 1'b1;
`ifdef UART_RX_FIFO_OVERWRITE_EN
      we         = 1'b1;
      wr_ptr_nxt = wr_ptr + AW'(1);
      rd_ptr_nxt = rd_ptr + AW'(1);
`else
      we         = 1'b0;
`endif
    end else if (pop) begin
      rd_ptr_nxt = rd_ptr + AW'(1);
      count_nxt  = count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == CW'(DEPTH));
      // Set wins over a same-cycle clear.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  uart_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  assign out_data = out_valid ? rdata : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based reference model, directed plan items, random traffic.
module tb_uart_rx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ack = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          overflow_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] sb_q[$];
  bit            m_ovf = 1'b0;

  uart_rx_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ack     (out_ack),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, updated from the inputs applied at each edge.
  always @(posedge clk or posedge reset) begin
    bit pop_m;
    bit set_m;
    if (reset) begin
      sb_q.delete();
      m_ovf = 1'b0;
    end else begin
      pop_m = out_ack && (sb_q.size() > 0);
      set_m = in_ready && !pop_m && (sb_q.size() == DEPTH);
      if (set_m) begin
`ifdef UART_RX_FIFO_OVERWRITE_EN
        void'(sb_q.pop_front());
        sb_q.push_back(in_data);
`endif
      end else begin
        if (pop_m) void'(sb_q.pop_front());
        if (in_ready) sb_q.push_back(in_data);
      end
      if (set_m) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
    end
  end

  // Monitor: compare presented head word and status against the model between edges.
  always @(negedge clk) begin
    if (!reset) begin
      check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      check("count", 32'(count), 32'(sb_q.size()));
      check("full", 32'(full), 32'(sb_q.size() == DEPTH));
      check("empty", 32'(empty), 32'(sb_q.size() == 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (sb_q.size() != 0) check("out_data", 32'(out_data), 32'(sb_q[0]));
      else check("out_data_idle", 32'(out_data), 32'h0);
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the edge that consumed them.
  task automatic step(input logic r, input logic [DW-1:0] d, input logic a, input logic c);
    in_ready     = r;
    in_data      = d;
    out_ack      = a;
    overflow_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_data"}, 32'(out_data), 32'h0);
    check({tag, "_count"}, 32'(count), 32'h0);
    check({tag, "_empty"}, 32'(empty), 32'h1);
    check({tag, "_full"}, 32'(full), 32'h0);
    check({tag, "_ovf"}, 32'(overflow), 32'h0);
  endtask

  logic [DW-1:0] exp_head;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b0;
    idle();

    // Single word through and out.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_data", 32'(out_data), 32'hA5);
    check("single_count", 32'(count), 32'h1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("single_pop_valid", 32'(out_valid), 32'h0);
    check("single_pop_data", 32'(out_data), 32'h0);
    check("single_pop_empty", 32'(empty), 32'h1);

    // Fill to DEPTH.
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    check("fill_full", 32'(full), 32'h1);
    check("fill_count", 32'(count), 32'(DEPTH));
    check("fill_ovf", 32'(overflow), 32'h0);

    // Push while full, then clear racing a second overflowing push, then a clean clear.
    step(1'b1, 8'h55, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'h1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    check("ovf_set_beats_clr", 32'(overflow), 32'h1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow), 32'h0);
`ifdef UART_RX_FIFO_OVERWRITE_EN
    exp_head = 8'h02;
`else
    exp_head = 8'h00;
`endif
    check("full_head", 32'(out_data), 32'(exp_head));

    // Simultaneous push and pop while full.
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("pp_full_count", 32'(count), 32'(DEPTH));
    check("pp_full_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < int'(DEPTH) && !empty; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 32'(empty), 32'h1);

    // Asynchronous reset between edges with words queued.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
    idle();
    #2 reset = 1'b1;
    #1 check_reset_values("async_rst");
    reset = 1'b0;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check("post_rst_data", 32'(out_data), 32'h3C);
    check("post_rst_count", 32'(count), 32'h1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with alternating consumer stall phases to reach full.
    for (int i = 0; i < 2000; i++) begin
      logic stall;
      stall = ((i / 100) % 2) == 1;
      step($urandom_range(0, 2) == 0, DW'($urandom),
           stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0),
           $urandom_range(0, 15) == 0);
    end

    for (int k = 0; k < 2 * int'(DEPTH) && sb_q.size() > 0; k++) step(1'b0, '0, 1'b1, 1'b0);
    idle();
    check("final_empty", 32'(empty), 32'h1);
    check("final_model_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
